// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: segment bit order,
// active-low hex glyph table and the blank pattern.
package seg_pkg;

    // o_seg bit order is {dp,g,f,e,d,c,b,a}
    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    typedef logic [6:0] glyph_t;

    localparam glyph_t     SEG_BLANK   = 7'h7F;
    localparam logic [7:0] SEG_ALL_OFF = 8'hFF;

    localparam glyph_t SEG_GLYPHS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_scan_display_if.sv
// Host-side bundle of the scanner: load/data/dp/freeze in, segment and digit drives out.
interface seg_scan_display_if #(
    parameter int unsigned DIGITS = 8
);
    logic                  load;
    logic [4*DIGITS-1:0]   data;
    logic [DIGITS-1:0]     dp_mask;
    logic                  freeze;
    logic [7:0]            o_seg;
    logic [DIGITS-1:0]     o_sel;
    logic                  frame_done;

    modport master (
        output load, data, dp_mask, freeze,
        input  o_seg, o_sel, frame_done
    );

    modport slave (
        input  load, data, dp_mask, freeze,
        output o_seg, o_sel, frame_done
    );
endinterface

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output glyph_t     glyph_o
);
    assign glyph_o = SEG_GLYPHS[nibble_i];
endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed hex display scanner with frame-aligned data commit.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS = 8,
    parameter int unsigned DIV    = 100000
)(
    input  logic            clk,
    input  logic            rst,
    seg_scan_display_if.slave bus
);
    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   disp_q, disp_d;
    logic [4*DIGITS-1:0]   pend_q, pend_d;
    logic                  pending_q, pending_d;
    logic [7:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     sel_q, sel_d;
    logic                  frame_done_q;

    logic                  tick;
    logic                  boundary;
    logic [3:0]            nibble;
    glyph_t                glyph;
    logic                  blank;

    seg_hex_decoder u_dec (
        .nibble_i (nibble),
        .glyph_o  (glyph)
    );

    always_comb begin
        tick     = (cnt_q == CNT_LAST) && !bus.freeze;
        boundary = tick && (idx_q == IDX_LAST);
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        if (tick) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end else if (!bus.freeze) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // A load landing on the boundary bypasses pend and commits directly.
    always_comb begin
        disp_d    = disp_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        if (!bus.freeze) begin
            if (boundary) begin
                if (bus.load) begin
                    disp_d    = bus.data;
                    pending_d = 1'b0;
                end else if (pending_q) begin
                    disp_d    = pend_q;
                    pending_d = 1'b0;
                end
            end else if (bus.load) begin
                pend_d    = bus.data;
                pending_d = 1'b1;
            end
        end
    end

    assign nibble = disp_q[4*idx_q +: 4];

`ifdef SEG_LZ_BLANK_EN
    // Blank when every nibble at or above the current digit is zero.
    always_comb begin
        blank = (idx_q != '0);
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (i >= 32'(idx_q) && disp_q[4*i +: 4] != 4'h0) begin
                blank = 1'b0;
            end
        end
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        sel_d                 = '1;
        sel_d[idx_q]          = 1'b0;
        seg_d                 = SEG_ALL_OFF;
        seg_d[SEG_G:SEG_A]    = blank ? SEG_BLANK : glyph;
        seg_d[SEG_DP]         = ~bus.dp_mask[idx_q];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pending_q    <= 1'b0;
            seg_q        <= SEG_ALL_OFF;
            sel_q        <= '1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            sel_q        <= sel_d;
            frame_done_q <= boundary;
        end
    end

    assign bus.o_seg      = seg_q;
    assign bus.o_sel      = sel_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display (DIGITS=8, DIV=4) with a scan-position reference model.
module tb_seg_scan_display;
    localparam int unsigned DIGITS = 8;
    localparam int unsigned DIV    = 4;
    localparam int unsigned TOTAL  = DIGITS * DIV;
`ifdef SEG_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    seg_scan_display_if #(.DIGITS(DIGITS)) bus ();

    seg_scan_display #(.DIGITS(DIGITS), .DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] seg;
        logic [7:0] sel;
        logic       fd;
    } exp_t;

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: one scan position covering the whole frame.
    int unsigned m_pos     = 0;
    logic [31:0] m_disp    = '0;
    logic [31:0] m_pend    = '0;
    bit          m_pending = 1'b0;

    logic [7:0] glyph_tab [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    task automatic step();
        exp_t        e;
        int unsigned d;
        logic [31:0] upper;
        logic [7:0]  g;
        if (!rst) begin
            e.seg = 8'hFF; e.sel = 8'hFF; e.fd = 1'b0;
            m_pos = 0; m_disp = '0; m_pend = '0; m_pending = 1'b0;
        end else begin
            d     = m_pos / DIV;
            upper = m_disp >> (4 * d);
            g     = glyph_tab[upper[3:0]];
            if (LZ && d != 0 && upper == 0) g = 8'hFF;
            g[7]  = ~bus.dp_mask[d];
            e.seg = g;
            e.sel = ~(8'h01 << d);
            e.fd  = !bus.freeze && (m_pos == TOTAL - 1);
            if (!bus.freeze) begin
                if (e.fd) begin
                    if (bus.load) begin
                        m_disp = bus.data; m_pending = 1'b0;
                    end else if (m_pending) begin
                        m_disp = m_pend; m_pending = 1'b0;
                    end
                end else if (bus.load) begin
                    m_pend = bus.data; m_pending = 1'b1;
                end
                m_pos = (m_pos + 1) % TOTAL;
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit r, input bit ld, input logic [31:0] dt,
                         input logic [7:0] dpm, input bit fz);
        rst         = r;
        bus.load    = ld;
        bus.data    = dt;
        bus.dp_mask = dpm;
        bus.freeze  = fz;
        step();
    endtask

    task automatic idle(input int n, input logic [7:0] dpm);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 32'h0, dpm, 1'b0);
    endtask

    task automatic run_to(input int unsigned target);
        int n = 0;
        while (m_pos != target && n < 2 * TOTAL) begin
            idle(1, 8'h00);
            n++;
        end
        checks++;
        if (m_pos != target) begin
            errors++;
            $display("FAIL run_to pos=%0d want=%0d", m_pos, target);
        end
    endtask

    task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp("o_seg", bus.o_seg, e.seg);
                cmp("o_sel", bus.o_sel, e.sel);
                cmp("frame_done", {7'h0, bus.frame_done}, {7'h0, e.fd});
            end
        end
    end

    initial begin
        logic [31:0] rd;
        bit          fz = 1'b0;
        bus.load = 1'b0; bus.data = '0; bus.dp_mask = '0; bus.freeze = 1'b0;

        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
        idle(70, 8'h00);

        run_to(10);
        drive(1'b1, 1'b1, 32'h1234ABCD, 8'h00, 1'b0);
        idle(2 * TOTAL, 8'h00);

        run_to(TOTAL - 1);
        drive(1'b1, 1'b1, 32'h00000003, 8'h00, 1'b0);
        idle(TOTAL, 8'h00);
        idle(TOTAL, 8'h01);

        run_to(13);
        for (int i = 0; i < 10; i++)
            drive(1'b1, (i == 5), 32'hDEADBEEF, 8'h00, 1'b1);
        idle(2 * TOTAL, 8'h00);

        run_to(TOTAL - 1);
        drive(1'b1, 1'b1, 32'h00000050, 8'h00, 1'b0);
        idle(TOTAL + 2, 8'h00);

        run_to(5);
        drive(1'b1, 1'b1, 32'h89ABCDEF, 8'h00, 1'b0);
        idle(3, 8'h00);
        drive(1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 8'h00, 1'b0);
        idle(TOTAL + 4, 8'h00);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) fz = !fz;
            rd = $urandom >> (4 * $urandom_range(0, 7));
            drive(($urandom_range(0, 499) != 0), ($urandom_range(0, 7) == 0), rd,
                  8'($urandom), fz);
        end
        idle(4, 8'h00);

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d want=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
